// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter and instruction register and
// performs single-outstanding reads from instruction memory with a two-state handshake.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        il_in,
    input  logic [1:0]  ps_in,
    input  logic [15:0] ra_in,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    output logic [15:0] ins_out,
    output logic [15:0] pc_out,
    output logic        fetch_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PS_HOLD   = 2'b00,
        PS_INC    = 2'b01,
        PS_BRANCH = 2'b10,
        PS_JUMP   = 2'b11
    } pc_sel_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q;
    logic        req_raw;
    logic        ir_load;
    logic [15:0] br_off;

    // Branch offset is a split 6-bit field {IR[8:6], IR[2:0]}, sign-extended.
    assign br_off = {{10{ir_q[8]}}, ir_q[8:6], ir_q[2:0]};

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (il_in) begin
                    req_raw = 1'b1;
                    if (!imem_ack) state_d = WAIT;
                end else begin
                    case (pc_sel_t'(ps_in))
                        PS_HOLD:   pc_d = pc_q;
                        PS_INC:    pc_d = pc_q + 16'd1;
                        PS_BRANCH: pc_d = pc_q + br_off;
                        PS_JUMP:   pc_d = ra_in;
                        default:   pc_d = pc_q;
                    endcase
                end
            end
            WAIT: begin
                req_raw = 1'b1;
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request is forced low while reset is asserted, even if il_in is high.
    assign imem_req   = req_raw & rst_n;
    assign ir_load    = imem_req & imem_ack;
    assign fetch_busy = imem_req & ~imem_ack;

    // PC cannot change while a fetch is pending, so it doubles as the latched
    // fetch address for the whole WAIT period.
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign ins_out   = ir_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) ir_q <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of single-cycle vectors plus
// hand-written wait-state and reset-during-wait sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        il_in;
    logic [1:0]  ps_in;
    logic [15:0] ra_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic [15:0] ins_out;
    logic [15:0] pc_out;
    logic        fetch_busy;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .il_in      (il_in),
        .ps_in      (ps_in),
        .ra_in      (ra_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .ins_out    (ins_out),
        .pc_out     (pc_out),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        il;
        logic [1:0]  ps;
        logic [15:0] ra;
        logic        ack;
        logic [15:0] rdata;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_busy;
        logic [15:0] exp_pc;
        logic [15:0] exp_ins;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] ins;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_vectors     = 0;
    int   n_checks      = 0;
    int   n_miscompares = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic il, input logic [1:0] ps,
                                input logic [15:0] ra, input logic ack, input logic [15:0] rdata,
                                input logic ereq, input logic [15:0] eaddr, input logic ebusy,
                                input logic [15:0] epc, input logic [15:0] eins);
        vec_t v;
        v.name = name; v.il = il; v.ps = ps; v.ra = ra; v.ack = ack; v.rdata = rdata;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_busy = ebusy;
        v.exp_pc = epc; v.exp_ins = eins;
        return v;
    endfunction

    // Called just after a rising edge: drive, check combinational outputs at the
    // falling edge, queue the post-edge register expectation, compare after the edge.
    task automatic apply(input vec_t v);
        sb_t e;
        il_in = v.il; ps_in = v.ps; ra_in = v.ra; imem_ack = v.ack; imem_rdata = v.rdata;
        n_vectors++;
        @(negedge clk);
        check({v.name, ".req"},  16'(imem_req),   16'(v.exp_req));
        check({v.name, ".addr"}, imem_addr,       v.exp_addr);
        check({v.name, ".busy"}, 16'(fetch_busy), 16'(v.exp_busy));
        sb.push_back('{name: v.name, pc: v.exp_pc, ins: v.exp_ins});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({v.name, ".sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, ".pc"},  pc_out,  e.pc);
            check({e.name, ".ins"}, ins_out, e.ins);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed expectations; each row is one cycle starting from the previous row's state.
        vecs.push_back(mk("fetch0_zero_wait", 1, 2'b00, 16'h0000, 1, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'h1234));
        vecs.push_back(mk("pc_inc",           0, 2'b01, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0001, 16'h1234));
        vecs.push_back(mk("jump_ffff",        0, 2'b11, 16'hFFFF, 0, 16'h0000, 0, 16'h0001, 0, 16'hFFFF, 16'h1234));
        vecs.push_back(mk("inc_wrap",         0, 2'b01, 16'h0000, 0, 16'h0000, 0, 16'hFFFF, 0, 16'h0000, 16'h1234));
        vecs.push_back(mk("jump_0010",        0, 2'b11, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h1234));
        vecs.push_back(mk("fetch_off_m2",     1, 2'b00, 16'h0000, 1, 16'h01C6, 1, 16'h0010, 0, 16'h0010, 16'h01C6));
        vecs.push_back(mk("branch_m2",        0, 2'b10, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'h000E, 16'h01C6));
        vecs.push_back(mk("jump_back_0010",   0, 2'b11, 16'h0010, 0, 16'h0000, 0, 16'h000E, 0, 16'h0010, 16'h01C6));
        vecs.push_back(mk("fetch_off_p31",    1, 2'b00, 16'h0000, 1, 16'h00C7, 1, 16'h0010, 0, 16'h0010, 16'h00C7));
        vecs.push_back(mk("branch_p31",       0, 2'b10, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'h002F, 16'h00C7));
        vecs.push_back(mk("jump_4000",        0, 2'b11, 16'h4000, 0, 16'h0000, 0, 16'h002F, 0, 16'h4000, 16'h00C7));
        vecs.push_back(mk("fetch_with_ps11",  1, 2'b11, 16'h1234, 1, 16'hBEEF, 1, 16'h4000, 0, 16'h4000, 16'hBEEF));
        vecs.push_back(mk("stray_ack_idle",   0, 2'b00, 16'h0000, 1, 16'h5555, 0, 16'h4000, 0, 16'h4000, 16'hBEEF));
        vecs.push_back(mk("branch_beef_p31",  0, 2'b10, 16'h0000, 0, 16'h0000, 0, 16'h4000, 0, 16'h401F, 16'hBEEF));
        vecs.push_back(mk("hold",             0, 2'b00, 16'h7777, 0, 16'h0000, 0, 16'h401F, 0, 16'h401F, 16'hBEEF));

        // Reset with il_in high: request must stay low.
        rst_n = 1'b0; il_in = 1'b1; ps_in = 2'b00; ra_in = '0; imem_ack = 1'b0; imem_rdata = '0;
        #3;
        check("rst.req",  16'(imem_req),   16'd0);
        check("rst.busy", 16'(fetch_busy), 16'd0);
        check("rst.addr", imem_addr,       16'h0000);
        check("rst.pc",   pc_out,          16'h0000);
        check("rst.ins",  ins_out,         16'h0000);
        il_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Multi-wait fetch: ack low for 3 cycles, ps_in=01 driven throughout.
        apply(mk("wait_c1", 1, 2'b01, 16'h0000, 0, 16'h0000, 1, 16'h401F, 1, 16'h401F, 16'hBEEF));
        apply(mk("wait_c2", 0, 2'b01, 16'h0000, 0, 16'h0000, 1, 16'h401F, 1, 16'h401F, 16'hBEEF));
        apply(mk("wait_c3", 0, 2'b01, 16'h0000, 0, 16'h0000, 1, 16'h401F, 1, 16'h401F, 16'hBEEF));
        apply(mk("wait_ack", 0, 2'b01, 16'h0000, 1, 16'hABCD, 1, 16'h401F, 0, 16'h401F, 16'hABCD));
        apply(mk("after_wait_idle", 0, 2'b00, 16'h0000, 0, 16'h0000, 0, 16'h401F, 0, 16'h401F, 16'hABCD));

        // Enter WAIT, then pulse reset mid-cycle: fetch must be abandoned.
        apply(mk("wait_pre_rst", 1, 2'b00, 16'h0000, 0, 16'h0000, 1, 16'h401F, 1, 16'h401F, 16'hABCD));
        il_in = 1'b0; imem_ack = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_wait.req",  16'(imem_req),   16'd0);
        check("rst_wait.busy", 16'(fetch_busy), 16'd0);
        check("rst_wait.addr", imem_addr,       16'h0000);
        check("rst_wait.pc",   pc_out,          16'h0000);
        check("rst_wait.ins",  ins_out,         16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk("late_ack", 0, 2'b00, 16'h0000, 1, 16'hDEAD, 0, 16'h0000, 0, 16'h0000, 16'h0000));
        apply(mk("post_rst_fetch", 1, 2'b00, 16'h0000, 1, 16'h0F0F, 1, 16'h0000, 0, 16'h0000, 16'h0F0F));

        if (sb.size() != 0) check("sb_leftover", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
